// File: rtl/approx_add_pipe.sv
// approx_add_pipe: pipelined adder whose N_APPROX LSBs can use carry-free
// approximate cells (per-transaction 'approx' bit), the remaining bits exact.
// The carry chain is split into CHUNK-bit ripple segments, one register
// stage per segment, with a global-advance valid/ready handshake.
// Optional feature macro: APPROX_ADD_ERRCNT_EN adds an exact shadow sum and
// a saturating err_cnt of results that differ from exact addition.
module approx_add_pipe #(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter int N_APPROX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef APPROX_ADD_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam int STAGES = WIDTH / CHUNK;

  // Whole pipe shifts together; a stalled output freezes every stage.
  logic adv;

  // Per-stage registered state, gathered so stage k can read stage k-1.
  logic             vld_s [STAGES];
  logic             apx_s [STAGES];
  logic             cy_s  [STAGES];
  logic [WIDTH-1:0] a_s   [STAGES];
  logic [WIDTH-1:0] b_s   [STAGES];
  logic [WIDTH-1:0] sm_s  [STAGES];
`ifdef APPROX_ADD_ERRCNT_EN
  logic [WIDTH:0]   ex_s  [STAGES];
`endif

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             p_vld, p_apx, p_cy;
      logic [WIDTH-1:0] p_a, p_b, p_sm;
      logic             vld_d, vld_q, apx_d, apx_q, cy_d, cy_q;
      logic [WIDTH-1:0] a_d, a_q, b_d, b_q, sm_d, sm_q;
`ifdef APPROX_ADD_ERRCNT_EN
      logic [WIDTH:0]   p_ex, ex_d, ex_q;
`endif

      if (gi == 0) begin : g_head
        // First stage takes the raw transaction; carry-in is cin.
        assign p_vld = in_valid;
        assign p_apx = approx;
        assign p_cy  = cin;
        assign p_a   = a;
        assign p_b   = b;
        assign p_sm  = '0;
`ifdef APPROX_ADD_ERRCNT_EN
        assign p_ex  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
`endif
      end else begin : g_body
        // Later stages continue from the previous stage's registers.
        assign p_vld = vld_s[gi-1];
        assign p_apx = apx_s[gi-1];
        assign p_cy  = cy_s[gi-1];
        assign p_a   = a_s[gi-1];
        assign p_b   = b_s[gi-1];
        assign p_sm  = sm_s[gi-1];
`ifdef APPROX_ADD_ERRCNT_EN
        assign p_ex  = ex_s[gi-1];
`endif
      end

      // Ripple this stage's CHUNK bits; approximate cells drop their carry-in.
      always_comb begin
        vld_d = p_vld;
        apx_d = p_apx;
        a_d   = p_a;
        b_d   = p_b;
        sm_d  = p_sm;
        cy_d  = p_cy;
        for (int j = 0; j < CHUNK; j++) begin
          if (p_apx && ((gi * CHUNK + j) < N_APPROX)) begin
            sm_d[gi*CHUNK+j] = p_a[gi*CHUNK+j] | p_b[gi*CHUNK+j];
            cy_d             = p_a[gi*CHUNK+j] & p_b[gi*CHUNK+j];
          end else begin
            sm_d[gi*CHUNK+j] = p_a[gi*CHUNK+j] ^ p_b[gi*CHUNK+j] ^ cy_d;
            cy_d             = (p_a[gi*CHUNK+j] & p_b[gi*CHUNK+j]) |
                               (cy_d & (p_a[gi*CHUNK+j] ^ p_b[gi*CHUNK+j]));
          end
        end
`ifdef APPROX_ADD_ERRCNT_EN
        ex_d = p_ex;
`endif
      end

      // Stage register: cleared by reset, loaded only when the pipe advances.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
          apx_q <= 1'b0;
          cy_q  <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          sm_q  <= '0;
`ifdef APPROX_ADD_ERRCNT_EN
          ex_q  <= '0;
`endif
        end else if (adv) begin
          vld_q <= vld_d;
          apx_q <= apx_d;
          cy_q  <= cy_d;
          a_q   <= a_d;
          b_q   <= b_d;
          sm_q  <= sm_d;
`ifdef APPROX_ADD_ERRCNT_EN
          ex_q  <= ex_d;
`endif
        end
      end

      assign vld_s[gi] = vld_q;
      assign apx_s[gi] = apx_q;
      assign cy_s[gi]  = cy_q;
      assign a_s[gi]   = a_q;
      assign b_s[gi]   = b_q;
      assign sm_s[gi]  = sm_q;
`ifdef APPROX_ADD_ERRCNT_EN
      assign ex_s[gi]  = ex_q;
`endif
    end
  endgenerate

  assign out_valid = vld_s[STAGES-1];
  assign sum       = sm_s[STAGES-1];
  assign cout      = cy_s[STAGES-1];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

`ifdef APPROX_ADD_ERRCNT_EN
  logic [15:0] err_cnt_d, err_cnt_q;

  // Count delivered results that differ from exact addition, saturating.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_valid && out_ready && ({cout, sum} != ex_s[STAGES-1]) &&
        (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 16'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
